// File: rtl/seg_pkg.sv
// Shared seven-segment tables and bit order, common to the display driver and this scan decoder.
package seg_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Active-high patterns, bit order g..a
    localparam logic [6:0] PAT_0 = 7'h3F;
    localparam logic [6:0] PAT_1 = 7'h06;
    localparam logic [6:0] PAT_2 = 7'h5B;
    localparam logic [6:0] PAT_3 = 7'h4F;
    localparam logic [6:0] PAT_4 = 7'h66;
    localparam logic [6:0] PAT_5 = 7'h6D;
    localparam logic [6:0] PAT_6 = 7'h7D;
    localparam logic [6:0] PAT_7 = 7'h07;
    localparam logic [6:0] PAT_8 = 7'h7F;
    localparam logic [6:0] PAT_9 = 7'h6F;

    localparam logic [6:0] BLANK_PAT  = 7'h00;
    localparam logic [3:0] BLANK_CODE = 4'hF;

endpackage

// File: rtl/seg_pattern_dec.sv
// Combinational decode of an active-high a..g pattern back to a BCD nibble.
module seg_pattern_dec
    import seg_pkg::*;
(
    input  logic [6:0] pat,
    output logic [3:0] code,
    output logic       blank,
    output logic       illegal
);

    always_comb begin
        code    = BLANK_CODE;
        blank   = 1'b0;
        illegal = 1'b0;
        case (pat)
            PAT_0:     code = 4'd0;
            PAT_1:     code = 4'd1;
            PAT_2:     code = 4'd2;
            PAT_3:     code = 4'd3;
            PAT_4:     code = 4'd4;
            PAT_5:     code = 4'd5;
            PAT_6:     code = 4'd6;
            PAT_7:     code = 4'd7;
            PAT_8:     code = 4'd8;
            PAT_9:     code = 4'd9;
            BLANK_PAT: blank = 1'b1;
            default:   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Samples multiplexed seg/com scan lines, captures each settled digit slot and rebuilds the display image.
module seg_scan_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYC     = 4,
    parameter int COM_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  seg,
    input  logic [3:0]  com,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic [3:0]  blank,
    output logic [3:0]  valid,
    output logic        frame_done,
    output logic        err_pattern,
    output logic        err_com
);

    localparam logic [7:0] STAB = 8'(STABLE_CYC);

    logic [7:0]  s_seg_q, s_seg_d;
    logic [3:0]  s_com_q, s_com_d;
    logic [11:0] prev_q, prev_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        done_q, done_d;
    logic [3:0]  seen_q, seen_d;
    logic [15:0] digits_q, digits_d;
    logic [3:0]  dp_q, dp_d;
    logic [3:0]  blank_q, blank_d;
    logic [3:0]  valid_q, valid_d;
    logic        frame_done_q, frame_done_d;
    logic        err_pattern_q, err_pattern_d;
    logic        err_com_q, err_com_d;

    logic [3:0] dec_code;
    logic       dec_blank;
    logic       dec_illegal;
    logic       same;
    logic       capture;
    logic       onehot;
    logic       multihot;
    logic [3:0] seen_next;

    seg_pattern_dec u_dec (
        .pat     (s_seg_q[SEG_G:SEG_A]),
        .code    (dec_code),
        .blank   (dec_blank),
        .illegal (dec_illegal)
    );

    always_comb begin
        s_seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg : seg;
        s_com_d = (COM_ACTIVE_LOW != 0) ? ~com : com;
        prev_d  = {s_com_q, s_seg_q};
        same    = (prev_d == prev_q);

        // A change restarts the run; capture fires once when a run first reaches STAB
        if (same) begin
            cnt_d = (cnt_q >= STAB) ? STAB : cnt_q + 8'd1;
        end else begin
            cnt_d = 8'd1;
        end
        capture = same && (cnt_d == STAB) && !done_q;
        done_d  = same && (done_q || capture);

        onehot   = (s_com_q != 4'd0) && ((s_com_q & (s_com_q - 4'd1)) == 4'd0);
        multihot = (s_com_q != 4'd0) && !onehot;

        digits_d      = digits_q;
        dp_d          = dp_q;
        blank_d       = blank_q;
        valid_d       = valid_q;
        seen_d        = seen_q;
        seen_next     = seen_q | s_com_q;
        frame_done_d  = 1'b0;
        err_pattern_d = 1'b0;
        err_com_d     = 1'b0;

        if (capture && onehot) begin
            if (dec_illegal) begin
                err_pattern_d = 1'b1;
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (s_com_q[i]) begin
                        digits_d[4*i +: 4] = dec_code;
                        dp_d[i]            = s_seg_q[SEG_DP];
                        blank_d[i]         = dec_blank;
                        valid_d[i]         = 1'b1;
                    end
                end
                if (seen_next == 4'b1111) begin
                    frame_done_d = 1'b1;
                    seen_d       = 4'b0000;
                end else begin
                    seen_d = seen_next;
                end
            end
        end else if (capture && multihot) begin
            err_com_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_seg_q       <= 8'd0;
            s_com_q       <= 4'd0;
            prev_q        <= 12'd0;
            cnt_q         <= 8'd0;
            done_q        <= 1'b0;
            seen_q        <= 4'd0;
            digits_q      <= 16'h0000;
            dp_q          <= 4'd0;
            blank_q       <= 4'd0;
            valid_q       <= 4'd0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            err_com_q     <= 1'b0;
        end else begin
            s_seg_q       <= s_seg_d;
            s_com_q       <= s_com_d;
            prev_q        <= prev_d;
            cnt_q         <= cnt_d;
            done_q        <= done_d;
            seen_q        <= seen_d;
            digits_q      <= digits_d;
            dp_q          <= dp_d;
            blank_q       <= blank_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            err_com_q     <= err_com_d;
        end
    end

    assign digits      = digits_q;
    assign dp          = dp_q;
    assign blank       = blank_q;
    assign valid       = valid_q;
    assign frame_done  = frame_done_q;
    assign err_pattern = err_pattern_q;
    assign err_com     = err_com_q;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Directed bench for seg_scan_decoder with active-low seg and com pins.
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  seg;
    logic [3:0]  com;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic [3:0]  valid;
    logic        frame_done;
    logic        err_pattern;
    logic        err_com;

    int checks = 0;
    int errors = 0;
    int n_fd   = 0;
    int n_ep   = 0;
    int n_ec   = 0;
    int base_fd, base_ep, base_ec;

    seg_scan_decoder #(
        .STABLE_CYC     (4),
        .COM_ACTIVE_LOW (1),
        .SEG_ACTIVE_LOW (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .seg         (seg),
        .com         (com),
        .digits      (digits),
        .dp          (dp),
        .blank       (blank),
        .valid       (valid),
        .frame_done  (frame_done),
        .err_pattern (err_pattern),
        .err_com     (err_com)
    );

    always #5 clk = ~clk;

    // Pulse counters: a pulse registered on edge k is seen here on edge k+1
    always @(posedge clk) begin
        if (frame_done === 1'b1)  n_fd <= n_fd + 1;
        if (err_pattern === 1'b1) n_ep <= n_ep + 1;
        if (err_com === 1'b1)     n_ec <= n_ec + 1;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold(input logic [3:0] c, input logic [7:0] s, input int n);
        @(negedge clk);
        com = c;
        seg = s;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic scan(input logic [3:0] c, input logic [7:0] s);
        hold(c, s, 6);
        hold(4'b1111, 8'hFF, 2);
    endtask

    task automatic snap();
        base_fd = n_fd;
        base_ep = n_ep;
        base_ec = n_ec;
    endtask

    initial begin
        rst_n = 1'b0;
        com   = 4'b1111;
        seg   = 8'hFF;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_digits", 32'(digits), 32'h0000);
        chk("reset_flags", {dp, blank, valid, frame_done, err_pattern, err_com}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: slot 0 shows "0"
        snap();
        hold(4'b1110, 8'hC0, 4);
        chk("t1_not_yet", 32'(valid), 32'h0);
        hold(4'b1111, 8'hFF, 1);
        chk("t1_digit0", 32'(digits[3:0]), 32'h0);
        chk("t1_valid", 32'(valid), 32'h1);
        chk("t1_blank", 32'(blank), 32'h0);
        hold(4'b1111, 8'hFF, 1);
        chk("t1_no_err", 32'((n_ep - base_ep) + (n_ec - base_ec)), 32'h0);

        // 2: full scan 1,2,3,4
        snap();
        scan(4'b1110, 8'hF9);
        scan(4'b1101, 8'hA4);
        scan(4'b1011, 8'hB0);
        hold(4'b0111, 8'h99, 4);
        chk("t2_fd_before", 32'(frame_done), 32'h0);
        hold(4'b0111, 8'h99, 1);
        chk("t2_fd_edge", 32'(frame_done), 32'h1);
        chk("t2_digits", 32'(digits), 32'h4321);
        chk("t2_valid", 32'(valid), 32'hF);
        hold(4'b0111, 8'h99, 1);
        chk("t2_fd_after", 32'(frame_done), 32'h0);
        hold(4'b1111, 8'hFF, 2);
        chk("t2_fd_count", 32'(n_fd - base_fd), 32'h1);

        // 3: short run on slot 2 ignored; full run captured once
        snap();
        hold(4'b1011, 8'h92, 3);
        hold(4'b1111, 8'hFF, 2);
        chk("t3_short_run", 32'(digits), 32'h4321);
        hold(4'b1011, 8'h92, 4);
        hold(4'b1011, 8'h92, 1);
        chk("t3_captured", 32'(digits), 32'h4521);
        hold(4'b1011, 8'h92, 20);
        hold(4'b1111, 8'hFF, 2);
        chk("t3_no_extra_fd", 32'(n_fd - base_fd), 32'h0);
        chk("t3_hold_digits", 32'(digits), 32'h4521);

        // 4: illegal 7'h49 on slot 1
        snap();
        hold(4'b1101, 8'hB6, 4);
        hold(4'b1111, 8'hFF, 1);
        chk("t4_err_pulse", 32'(err_pattern), 32'h1);
        chk("t4_digit1", 32'(digits[7:4]), 32'h2);
        chk("t4_valid1", 32'(valid[1]), 32'h1);
        hold(4'b1111, 8'hFF, 1);
        chk("t4_err_clear", 32'(err_pattern), 32'h0);
        chk("t4_err_count", 32'(n_ep - base_ep), 32'h1);

        // 5: multi-hot com, then dark slot 3, then "7." on slot 0
        snap();
        hold(4'b1100, 8'hF9, 4);
        hold(4'b1111, 8'hFF, 1);
        chk("t5_err_com", 32'(err_com), 32'h1);
        chk("t5_digits", 32'(digits), 32'h4521);
        hold(4'b1111, 8'hFF, 1);
        chk("t5_ec_count", 32'(n_ec - base_ec), 32'h1);
        scan(4'b0111, 8'hFF);
        chk("t5_dark_digit", 32'(digits[15:12]), 32'hF);
        chk("t5_dark_blank", 32'(blank), 32'h8);
        chk("t5_dark_dp", 32'(dp), 32'h0);
        scan(4'b1110, 8'h78);
        chk("t5_dp_digit", 32'(digits[3:0]), 32'h7);
        chk("t5_dp_set", 32'(dp), 32'h1);
        chk("t5_no_fd", 32'(n_fd - base_fd), 32'h0);

        // 6: reset mid-run with slots 0,2,3 seen
        hold(4'b1101, 8'hA4, 2);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("t6_rst_digits", 32'(digits), 32'h0000);
        chk("t6_rst_flags", {dp, blank, valid, frame_done, err_pattern, err_com}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        snap();
        repeat (4) @(posedge clk);
        #1;
        chk("t6_full_run_needed", 32'(valid), 32'h0);
        @(posedge clk);
        #1;
        chk("t6_slot1", 32'(valid), 32'h2);
        chk("t6_fd_slot1", 32'(frame_done), 32'h0);
        hold(4'b1101, 8'hA4, 1);
        hold(4'b1111, 8'hFF, 2);
        scan(4'b1110, 8'hF9);
        scan(4'b1011, 8'hB0);
        chk("t6_no_fd_3slots", 32'(n_fd - base_fd), 32'h0);
        hold(4'b0111, 8'h99, 5);
        chk("t6_fd_edge", 32'(frame_done), 32'h1);
        chk("t6_digits", 32'(digits), 32'h4321);
        hold(4'b1111, 8'hFF, 2);
        chk("t6_fd_count", 32'(n_fd - base_fd), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
